// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART constants, receiver state encoding, baud divisor.
// Revision : 1.0
// ============================================================================
package uart_pkg;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_BAUD     = 9600;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_START = S_START,
      ST_DATA  = S_DATA,
      ST_STOP  = S_STOP
   } rx_state_e;

   // Clocks per bit-time, truncated; the TX side divides by the same value.
   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// uart_rx_sync : two-flop synchroniser for an async serial line plus a
//                falling-edge flag on the synchronised value.
// Revision     : 1.0
// ============================================================================
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic rx_s_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rx_s_o = sync_q;
   assign fall_o = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// uart_byte_rx : 8N1 UART receiver with start-glitch rejection, frame-error
//                strobe and line-idle indication.
// Revision     : 1.0
// ============================================================================
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = DEF_CLK_FREQ,
   parameter int BAUD      = DEF_BAUD,
   parameter int IDLE_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       dout_vld,
   output logic       frame_err,
   output logic       line_idle,
   output logic       busy
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
   localparam int HALF     = BAUD_DIV / 2;
   localparam int IDLE_SAT = IDLE_BITS * BAUD_DIV;
   localparam int CW       = $clog2(BAUD_DIV);
   localparam int IW       = $clog2(IDLE_SAT + 1);

   localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] C_MID  = CW'(HALF - 1);
   localparam logic [IW-1:0] C_SAT  = IW'(IDLE_SAT);

   logic w_rx_s;
   logic w_fall;
   logic w_idle_clr;

   rx_state_e     state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [2:0]    bit_q,      bit_d;
   logic [7:0]    shift_q,    shift_d;
   logic [7:0]    dout_q,     dout_d;
   logic          vld_q,      vld_d;
   logic          err_q,      err_d;
   logic          busy_q,     busy_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic          idle_sat_q, idle_sat_d;

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .rx_i   (rx),
      .rx_s_o (w_rx_s),
      .fall_o (w_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         dout_q     <= '0;
         vld_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         idle_cnt_q <= '0;
         idle_sat_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         dout_q     <= dout_d;
         vld_q      <= vld_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         idle_cnt_q <= idle_cnt_d;
         idle_sat_q <= idle_sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_fall) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == C_MID) begin
               if (!w_rx_s) begin
                  state_d = ST_DATA;
                  bit_d   = 3'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (cnt_q == C_LAST) begin
               shift_d[bit_q] = w_rx_s;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            // Leave at mid stop bit so an abutting start bit is not missed.
            if (cnt_q == C_LAST) begin
               state_d = ST_IDLE;
               if (w_rx_s) begin
                  vld_d  = 1'b1;
                  dout_d = shift_q;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q || state_q == ST_IDLE) begin
         cnt_d = '0;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // Idle indication is gated by the clear term so it falls on the very
   // first low synchronised cycle rather than one clock later.
   always_comb begin
      w_idle_clr = !w_rx_s || (state_q != ST_IDLE);
      if (w_idle_clr) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q == C_SAT) begin
         idle_cnt_d = idle_cnt_q;
      end else begin
         idle_cnt_d = idle_cnt_q + IW'(1);
      end
      idle_sat_d = (idle_cnt_d == C_SAT);
   end

   assign dout      = dout_q;
   assign dout_vld  = vld_q;
   assign frame_err = err_q;
   assign busy      = busy_q;
   assign line_idle = idle_sat_q & ~w_idle_clr;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_byte_rx : directed plus randomised frames against a byte-level
//                   expectation queue.
// Revision        : 1.0
// ============================================================================
module tb_uart_byte_rx;

   localparam int BD   = 10;
   localparam int HALF = BD / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] dout;
   logic       dout_vld;
   logic       frame_err;
   logic       line_idle;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         err_n  = 0;
   int         both_n = 0;
   int         cyc    = 0;
   int         vld_cyc = 0;
   logic [7:0] err_dout = 8'h00;

   uart_byte_rx #(
      .CLK_FREQ  (1000),
      .BAUD      (100),
      .IDLE_BITS (20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .dout      (dout),
      .dout_vld  (dout_vld),
      .frame_err (frame_err),
      .line_idle (line_idle),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (dout_vld) begin
         got_q.push_back(dout);
         vld_cyc = cyc;
      end
      if (frame_err) begin
         err_n++;
         err_dout = dout;
      end
      if (dout_vld && frame_err) both_n++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      tick(BD);
   endtask

   task automatic send_tail(input logic [7:0] b, input logic stop);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
      drive_bit(1'b0);
      send_tail(b, stop);
      repeat (gap) drive_bit(1'b1);
   endtask

   initial begin
      int         n0;
      int         e0;
      int         start_cyc;
      int         lat;
      int         exp_err;
      logic [7:0] last_good;
      logic [7:0] b;
      logic       ok;
      int         gap;

      rx  = 1'b1;
      rst = 1'b1;
      tick(3);
      chk("rst_dout", dout, 8'h00);
      chk("rst_vld", dout_vld, 1'b0);
      chk("rst_err", frame_err, 1'b0);
      chk("rst_idle", line_idle, 1'b1);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;

      // Idle counter restarts from zero after reset: 200 clocks of high line.
      tick(100);
      chk("idle_not_yet", line_idle, 1'b0);
      tick(105);
      chk("idle_before_start", line_idle, 1'b1);

      // Frame 0x55, observing line_idle through the synchroniser delay.
      start_cyc = cyc;
      rx = 1'b0;
      tick(1);
      chk("idle_sync_delay", line_idle, 1'b1);
      tick(1);
      chk("idle_drop", line_idle, 1'b0);
      tick(BD - 2);
      send_tail(8'h55, 1'b1);
      drive_bit(1'b1);
      chk("f55_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("f55_byte", got_q[0], 8'h55);
      chk("f55_no_err", err_n, 0);
      lat = vld_cyc - start_cyc;
      chk("f55_latency", (lat >= 2 + HALF + 9 * BD && lat <= 3 + HALF + 9 * BD), 1'b1);
      chk("f55_busy_low", busy, 1'b0);
      for (int i = 0; i < 400 && cyc < vld_cyc + 199; i++) tick(1);
      chk("idle_after_199", line_idle, 1'b0);
      tick(1);
      chk("idle_after_200", line_idle, 1'b1);
      last_good = 8'h55;

      // Back-to-back frames with no gap between stop and next start.
      n0 = got_q.size();
      exp_q = '{8'h01, 8'h01, 8'h02, 8'h80};
      foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      chk("b2b_count", got_q.size(), n0 + 4);
      foreach (exp_q[i])
         if (n0 + i < got_q.size()) chk("b2b_byte", got_q[n0 + i], exp_q[i]);
      last_good = 8'h80;

      // Three-clock glitch on an idle line.
      n0 = got_q.size();
      e0 = err_n;
      rx = 1'b0;
      tick(3);
      chk("glitch_busy_high", busy, 1'b1);
      rx = 1'b1;
      tick(HALF);
      chk("glitch_busy_low", busy, 1'b0);
      tick(2 * BD);
      chk("glitch_no_vld", got_q.size(), n0);
      chk("glitch_no_err", err_n, e0);

      // Frame 0xA3 with a low stop bit.
      e0 = err_n;
      send_frame(8'hA3, 1'b0, 1);
      drive_bit(1'b1);
      chk("ferr_count", err_n, e0 + 1);
      chk("ferr_no_vld", got_q.size(), n0);
      chk("ferr_dout_at_strobe", err_dout, last_good);
      chk("ferr_dout_held", dout, last_good);

      // Break: line held low for many bit-times reports once.
      e0 = err_n;
      rx = 1'b0;
      tick(25 * BD);
      rx = 1'b1;
      tick(2 * BD);
      chk("break_one_err", err_n, e0 + 1);
      chk("break_no_vld", got_q.size(), n0);
      chk("break_busy", busy, 1'b0);

      // Reset in the middle of the data bits of 0xFF.
      e0 = err_n;
      drive_bit(1'b0);
      repeat (3) drive_bit(1'b1);
      tick(HALF);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_dout", dout, 8'h00);
      chk("mid_rst_vld", dout_vld, 1'b0);
      chk("mid_rst_err", frame_err, 1'b0);
      chk("mid_rst_idle", line_idle, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick(HALF);
      repeat (6) drive_bit(1'b1);
      chk("mid_rst_no_vld", got_q.size(), n0);
      chk("mid_rst_no_err", err_n, e0);
      send_frame(8'h3C, 1'b1, 1);
      chk("post_rst_count", got_q.size(), n0 + 1);
      if (got_q.size() > n0) chk("post_rst_byte", got_q[n0], 8'h3C);
      last_good = 8'h3C;

      // Randomised frames: a good stop bit yields the byte, a bad one an error.
      n0 = got_q.size();
      e0 = err_n;
      exp_q = {};
      exp_err = 0;
      for (int k = 0; k < 24; k++) begin
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 3) != 0);
         gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         send_frame(b, ok, gap);
         if (ok) begin
            exp_q.push_back(b);
            last_good = b;
         end else begin
            exp_err++;
         end
      end
      drive_bit(1'b1);
      drive_bit(1'b1);
      chk("rand_count", got_q.size(), n0 + exp_q.size());
      foreach (exp_q[i]) begin
         if (n0 + i < got_q.size()) chk("rand_byte", got_q[n0 + i], exp_q[i]);
      end
      chk("rand_errs", err_n, e0 + exp_err);
      chk("rand_dout_last", dout, last_good);
      chk("vld_err_exclusive", both_n, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial receiver placed directly upstream of the register-config parser.
- Converts the asynchronous UART line from the host into byte strobes (dout/dout_vld), which the parser consumes as address/data pairs for config_en, gray_value and radius.
- Supports 8N1 framing only.
- Adds start-bit glitch rejection, frame-error reporting and a line-idle indication, so the parser can be resynchronised between command pairs.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer truncation), must be >= 4
IDLE_BITS, 20, bit-times of continuous high line after which line_idle is asserted

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
rx  input  1  asynchronous serial line, idle high
dout  output  8  last correctly received byte
dout_vld  output  1  one-cycle strobe, dout valid on the same cycle
frame_err  output  1  one-cycle strobe, stop bit sampled low
line_idle  output  1  level, line high for >= IDLE_BITS bit-times
busy  output  1  level, high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values: dout=0, dout_vld=0, frame_err=0, line_idle=1, busy=0, state=IDLE, synchroniser flops=1, all counters=0.
- rx passes through a 2-flop synchroniser (rx_s). A third flop supplies the previous value for falling-edge detection. Only rx_s is ever sampled.
- A single baud counter runs 0..BAUD_DIV-1. It is cleared on every state change. HALF = BAUD_DIV/2.
- IDLE: on a falling edge of rx_s, go to START.
- START: at count HALF-1, sample rx_s.
  - rx_s=0: go to DATA, bit index=0.
  - rx_s=1 (glitch): return to IDLE with no strobe.
- DATA: at count BAUD_DIV-1, sample rx_s into shift[bit index]. Bits arrive LSB first. After bit 7, go to STOP.
- STOP: at count BAUD_DIV-1, sample rx_s.
  - rx_s=1: on the next cycle, dout=shift and dout_vld=1 for exactly one cycle.
  - rx_s=0: frame_err=1 for exactly one cycle; dout is held; no dout_vld.
  - Either way, return to IDLE at the sample point (mid stop bit), so a start bit immediately following the stop bit is caught.
- Latency: dout_vld rises 1 clk after the mid-stop-bit sample, i.e. about 2 + HALF + 9*BAUD_DIV clocks after the rx falling edge.
- dout_vld and frame_err are never high together.
- A break condition (line held low) produces frame_err once. The receiver then stays in IDLE until rx_s rises and falls again; there is no repeated re-triggering during the low period.
- Idle counter: cleared whenever rx_s=0 or state != IDLE. Otherwise it increments, saturating at IDLE_BITS*BAUD_DIV. line_idle = (counter == saturation value). line_idle drops on the first cycle the counter is cleared.
- busy = (state != IDLE), registered with the state.
- rst asserted mid-frame: the partial byte is discarded and no strobe is emitted. Reset values apply on the next clock edge.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3;
  - default CLK_FREQ/BAUD constants;
  - a BAUD_DIV helper function (shared with a future uart_byte_tx).
- One natural sub-module: uart_rx_sync, the 2-flop synchroniser plus falling-edge detect, reusable by the TX-side break detector.
- The FSM, counters and output registers stay in uart_byte_rx.

Test Plan:
- CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10). Send frame 8'h55 with a good stop bit -> exactly one dout_vld pulse, dout=8'h55, frame_err stays 0, busy low after the stop-bit midpoint.
- Back-to-back bytes 8'h01, 8'h01, 8'h02, 8'h80 with no gap between stop and next start -> four dout_vld pulses, in order, with no lost byte.
- Low pulse of 3 clks on an idle line -> START aborts, no dout_vld, no frame_err, busy returns to 0 within HALF+3 clks.
- Frame 8'hA3 with the stop bit driven 0 -> one frame_err pulse, no dout_vld, dout keeps its previous value (8'h80 after the prior test).
- Line held high for 20*10 clks after reset, then a start bit -> line_idle=1 before the start bit, 0 on the first low synchronised cycle, 1 again 200 clks after the frame ends.
- Assert rst for 1 clk in the middle of DATA of 8'hFF -> no strobe; outputs return to reset values; the next clean frame 8'h3C is received correctly.
